// File: rtl/hm_nonce_dispatcher.sv
// hm_nonce_dispatcher: splices nonces into a chunk template and launches
// one hash at a time, stepping an interleaved nonce range until hit or end.
module hm_nonce_dispatcher #(
   parameter int unsigned MODULE_NUM  = 0,
   parameter int unsigned NUM_MODULES = 1
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start_mining,
   input  logic         stop_mining,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic [511:0] chunk_template,
   input  logic         hash_done,
   input  logic         valid_hash_flag,
   input  logic [255:0] valid_hash,
   output logic         begin_hash,
   output logic         quit_hash,
   output logic [511:0] data_to_hash,
   output logic         busy,
   output logic         found,
   output logic         exhausted,
   output logic [31:0]  found_nonce,
   output logic [255:0] found_hash,
   output logic [31:0]  hash_count
);

   typedef enum logic [2:0] {
      IDLE, LOAD, LAUNCH, WAIT, ABORT, FOUND, EXHAUST
   } state_t;

   state_t       state_q, state_d;
   logic [32:0]  nonce_q;
   logic [31:0]  end_q;
   logic [511:0] tmpl_q;
   logic [32:0]  first_nonce, next_nonce;
   logic         do_start, do_step, do_count, do_cap;

   // 33-bit arithmetic so the range check never wraps past 0xFFFFFFFF
   assign first_nonce = {1'b0, nonce_start} + 33'(MODULE_NUM);
   assign next_nonce  = nonce_q + 33'(NUM_MODULES);

   always_comb begin
      state_d  = state_q;
      do_start = 1'b0;
      do_step  = 1'b0;
      do_count = 1'b0;
      do_cap   = 1'b0;
      unique case (state_q)
         IDLE, FOUND, EXHAUST: begin
            if (stop_mining) begin
               state_d = IDLE;
            end else if (start_mining) begin
               state_d  = LOAD;
               do_start = 1'b1;
            end
         end
         LOAD: begin
            if (stop_mining)
               state_d = ABORT;
            else if (nonce_q > {1'b0, end_q})
               state_d = EXHAUST;
            else
               state_d = LAUNCH;
         end
         LAUNCH: begin
            state_d = stop_mining ? ABORT : WAIT;
         end
         WAIT: begin
            // a hit reported alongside stop is kept rather than thrown away
            if (hash_done && valid_hash_flag) begin
               state_d  = FOUND;
               do_cap   = 1'b1;
               do_count = 1'b1;
            end else if (stop_mining) begin
               state_d = ABORT;
            end else if (hash_done) begin
               do_count = 1'b1;
               if (next_nonce > {1'b0, end_q}) begin
                  state_d = EXHAUST;
               end else begin
                  state_d = LOAD;
                  do_step = 1'b1;
               end
            end
         end
         ABORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         nonce_q      <= '0;
         end_q        <= '0;
         tmpl_q       <= '0;
         data_to_hash <= '0;
         found_nonce  <= '0;
         found_hash   <= '0;
         hash_count   <= '0;
      end else begin
         if (do_start) begin
            tmpl_q      <= chunk_template;
            end_q       <= nonce_end;
            nonce_q     <= first_nonce;
            found_nonce <= '0;
            found_hash  <= '0;
            hash_count  <= '0;
         end
         if (do_step)
            nonce_q <= next_nonce;
         if (state_q == LOAD)
            data_to_hash <= {tmpl_q[511:416], nonce_q[31:0], tmpl_q[383:0]};
         if (do_count && hash_count != 32'hFFFF_FFFF)
            hash_count <= hash_count + 32'd1;
         if (do_cap) begin
            found_nonce <= nonce_q[31:0];
            found_hash  <= valid_hash;
         end
      end
   end

   assign begin_hash = (state_q == LAUNCH);
   assign quit_hash  = (state_q == ABORT);
   assign busy       = (state_q == LOAD) || (state_q == LAUNCH) ||
                       (state_q == WAIT) || (state_q == ABORT);
   assign found      = (state_q == FOUND);
   assign exhausted  = (state_q == EXHAUST);

endmodule

// File: tb/tb_hm_nonce_dispatcher.sv
// Bench for hm_nonce_dispatcher: hashing-module models, launch scoreboard,
// and directed scenarios on a stride-1 and a stride-4 instance.
module tb_hm_nonce_dispatcher;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start0 = 1'b0, start1 = 1'b0, stop = 1'b0;
   logic [31:0]  nstart = '0, nend = '0;
   logic [511:0] tmpl = '0;
   logic         m_hd0 = 1'b0, m_vf0 = 1'b0, t_hd0 = 1'b0, t_vf0 = 1'b0;
   logic         m_hd1 = 1'b0;
   logic         hd0, vf0, hd1;
   logic [255:0] vh0 = '0;

   logic         bh0, qh0, busy0, fnd0, exh0;
   logic [511:0] d0;
   logic [31:0]  fn0, hc0;
   logic [255:0] fh0;
   logic         bh1, qh1, busy1, fnd1, exh1;
   logic [511:0] d1;
   logic [31:0]  fn1, hc1;
   logic [255:0] fh1;

   int checks = 0, errors = 0;
   int cyc = 0, trig0 = 0, trig1 = 0;
   int launches0 = 0, launches1 = 0, quits0 = 0;
   int valid_idx0 = -1;
   bit hm_en0 = 1'b0, hm_en1 = 1'b0;
   logic [31:0]  exp0[$], exp1[$];
   logic [31:0]  m_e;
   logic [511:0] m_d;

   assign hd0 = m_hd0 | t_hd0;
   assign vf0 = m_vf0 | t_vf0;
   assign hd1 = m_hd1;

   always #5 clk = ~clk;

   hm_nonce_dispatcher #(.MODULE_NUM(0), .NUM_MODULES(1)) u_dut0 (
      .clk(clk), .n_rst(rst_n),
      .start_mining(start0), .stop_mining(stop),
      .nonce_start(nstart), .nonce_end(nend), .chunk_template(tmpl),
      .hash_done(hd0), .valid_hash_flag(vf0), .valid_hash(vh0),
      .begin_hash(bh0), .quit_hash(qh0), .data_to_hash(d0),
      .busy(busy0), .found(fnd0), .exhausted(exh0),
      .found_nonce(fn0), .found_hash(fh0), .hash_count(hc0)
   );

   hm_nonce_dispatcher #(.MODULE_NUM(1), .NUM_MODULES(4)) u_dut1 (
      .clk(clk), .n_rst(rst_n),
      .start_mining(start1), .stop_mining(stop),
      .nonce_start(nstart), .nonce_end(nend), .chunk_template(tmpl),
      .hash_done(hd1), .valid_hash_flag(1'b0), .valid_hash(256'h0),
      .begin_hash(bh1), .quit_hash(qh1), .data_to_hash(d1),
      .busy(busy1), .found(fnd1), .exhausted(exh1),
      .found_nonce(fn1), .found_hash(fh1), .hash_count(hc1)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (start0 || hd0) trig0 <= cyc;
      if (start1 || hd1) trig1 <= cyc;
   end

   // hashing module models: hash_done 70 cycles after each begin_hash
   always begin
      @(negedge clk);
      if (hm_en0 && bh0) begin
         launches0++;
         repeat (69) @(negedge clk);
         m_vf0 = (launches0 == valid_idx0);
         m_hd0 = 1'b1;
         @(negedge clk);
         m_hd0 = 1'b0;
         m_vf0 = 1'b0;
      end
   end

   always begin
      @(negedge clk);
      if (hm_en1 && bh1) begin
         launches1++;
         repeat (69) @(negedge clk);
         m_hd1 = 1'b1;
         @(negedge clk);
         m_hd1 = 1'b0;
      end
   end

   // launch scoreboard
   always @(negedge clk) begin
      if (qh0) quits0++;
      if (bh0) begin
         checks++;
         if (exp0.size() == 0) begin
            errors++;
            $display("FAIL launch0_unexpected: nonce %h, none expected",
                     d0[415:384]);
         end else begin
            m_e = exp0.pop_front();
            m_d = {tmpl[511:416], m_e, tmpl[383:0]};
            if (d0 !== m_d) begin
               errors++;
               $display("FAIL launch0_data: nonce field %h, expected %h",
                        d0[415:384], m_e);
            end
            checks++;
            if (cyc - trig0 != 2) begin
               errors++;
               $display("FAIL launch0_latency: %0d cycles, expected 2",
                        cyc - trig0);
            end
         end
      end
      if (bh1) begin
         checks++;
         if (exp1.size() == 0) begin
            errors++;
            $display("FAIL launch1_unexpected: nonce %h, none expected",
                     d1[415:384]);
         end else begin
            m_e = exp1.pop_front();
            m_d = {tmpl[511:416], m_e, tmpl[383:0]};
            if (d1 !== m_d) begin
               errors++;
               $display("FAIL launch1_data: nonce field %h, expected %h",
                        d1[415:384], m_e);
            end
            checks++;
            if (cyc - trig1 != 2) begin
               errors++;
               $display("FAIL launch1_latency: %0d cycles, expected 2",
                        cyc - trig1);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic pulse_start0();
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic pulse_stop();
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic new_template();
      for (int i = 0; i < 16; i++) tmpl[i*32 +: 32] = $urandom;
   endtask

   task automatic wait_launched0();
      for (int i = 0; i < 20 && exp0.size() != 0; i++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bh0, qh0, busy0, fnd0, exh0} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags0: %b, expected 00000",
                  {bh0, qh0, busy0, fnd0, exh0});
      end
      checks++;
      if (d0 !== '0) begin
         errors++;
         $display("FAIL reset_data0: %h, expected 0", d0);
      end
      checks++;
      if ({fn0, hc0} !== 64'h0 || fh0 !== '0) begin
         errors++;
         $display("FAIL reset_result0: nonce %h count %h hash %h, expected 0",
                  fn0, hc0, fh0);
      end
      checks++;
      if ({bh1, qh1, busy1, fnd1, exh1, fn1, hc1} !== '0 ||
          d1 !== '0 || fh1 !== '0) begin
         errors++;
         $display("FAIL reset_dut1: flags %b, expected 0",
                  {bh1, qh1, busy1, fnd1, exh1});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_exhaust();
      int l0;
      new_template();
      nstart = 32'h10;
      nend = 32'h12;
      l0 = launches0;
      valid_idx0 = -1;
      hm_en0 = 1'b1;
      exp0.push_back(32'h10);
      exp0.push_back(32'h11);
      exp0.push_back(32'h12);
      pulse_start0();
      repeat (3) @(negedge clk);
      checks++;
      if (busy0 !== 1'b1) begin
         errors++;
         $display("FAIL exhaust_busy: %b, expected 1", busy0);
      end
      for (int i = 0; i < 1000 && !exh0; i++) @(negedge clk);
      checks++;
      if ({exh0, fnd0, busy0} !== 3'b100) begin
         errors++;
         $display("FAIL exhaust_flags: exh/fnd/busy %b, expected 100",
                  {exh0, fnd0, busy0});
      end
      checks++;
      if (hc0 !== 32'd3 || launches0 - l0 != 3) begin
         errors++;
         $display("FAIL exhaust_count: hash_count %0d launches %0d, expected 3",
                  hc0, launches0 - l0);
      end
      checks++;
      if (exp0.size() != 0) begin
         errors++;
         $display("FAIL exhaust_pending: %0d launches missing, expected 0",
                  exp0.size());
      end
   endtask

   task automatic test_found();
      int l0;
      new_template();
      nstart = 32'h10;
      nend = 32'h12;
      vh0 = 256'h0ABC;
      l0 = launches0;
      valid_idx0 = launches0 + 2;
      exp0.push_back(32'h10);
      exp0.push_back(32'h11);
      pulse_start0();
      for (int i = 0; i < 1000 && !fnd0 && !exh0; i++) @(negedge clk);
      checks++;
      if ({fnd0, exh0, busy0} !== 3'b100) begin
         errors++;
         $display("FAIL found_flags: fnd/exh/busy %b, expected 100",
                  {fnd0, exh0, busy0});
      end
      checks++;
      if (fn0 !== 32'h11) begin
         errors++;
         $display("FAIL found_nonce: %h, expected 00000011", fn0);
      end
      checks++;
      if (fh0 !== 256'h0ABC) begin
         errors++;
         $display("FAIL found_hash: %h, expected 0abc", fh0);
      end
      checks++;
      if (hc0 !== 32'd2) begin
         errors++;
         $display("FAIL found_count: %0d, expected 2", hc0);
      end
      repeat (100) @(negedge clk);
      checks++;
      if (launches0 - l0 != 2 || fnd0 !== 1'b1) begin
         errors++;
         $display("FAIL found_hold: launches %0d found %b, expected 2 and 1",
                  launches0 - l0, fnd0);
      end
   endtask

   task automatic test_stride();
      new_template();
      nstart = 32'h0;
      nend = 32'h9;
      hm_en1 = 1'b1;
      exp1.push_back(32'h1);
      exp1.push_back(32'h5);
      exp1.push_back(32'h9);
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 1000 && !exh1; i++) @(negedge clk);
      checks++;
      if ({exh1, fnd1, busy1} !== 3'b100) begin
         errors++;
         $display("FAIL stride_flags: exh/fnd/busy %b, expected 100",
                  {exh1, fnd1, busy1});
      end
      checks++;
      if (hc1 !== 32'd3 || launches1 != 3 || exp1.size() != 0) begin
         errors++;
         $display("FAIL stride_count: count %0d launches %0d left %0d, expected 3 3 0",
                  hc1, launches1, exp1.size());
      end
      hm_en1 = 1'b0;
   endtask

   task automatic test_wrap();
      int l0;
      new_template();
      nstart = 32'hFFFF_FFFE;
      nend = 32'hFFFF_FFFF;
      l0 = launches0;
      valid_idx0 = -1;
      exp0.push_back(32'hFFFF_FFFE);
      exp0.push_back(32'hFFFF_FFFF);
      pulse_start0();
      for (int i = 0; i < 1000 && !exh0; i++) @(negedge clk);
      repeat (100) @(negedge clk);
      checks++;
      if (exh0 !== 1'b1 || hc0 !== 32'd2 || launches0 - l0 != 2) begin
         errors++;
         $display("FAIL wrap_end: exh %b count %0d launches %0d, expected 1 2 2",
                  exh0, hc0, launches0 - l0);
      end
      nstart = 32'h5;
      nend = 32'h4;
      l0 = launches0;
      pulse_start0();
      repeat (5) @(negedge clk);
      checks++;
      if (exh0 !== 1'b1 || hc0 !== 32'd0 || launches0 != l0) begin
         errors++;
         $display("FAIL empty_range: exh %b count %0d launches %0d, expected 1 0 0",
                  exh0, hc0, launches0 - l0);
      end
      hm_en0 = 1'b0;
   endtask

   task automatic test_stop();
      int q;
      new_template();
      nstart = 32'h10;
      nend = 32'h12;
      exp0.push_back(32'h10);
      pulse_start0();
      wait_launched0();
      repeat (10) @(negedge clk);
      q = quits0;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if (qh0 !== 1'b1 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL stop_quit: quit %b busy %b, expected 1 1", qh0, busy0);
      end
      @(negedge clk);
      checks++;
      if ({qh0, busy0, fnd0, exh0} !== 4'b0) begin
         errors++;
         $display("FAIL stop_idle: quit/busy/fnd/exh %b, expected 0000",
                  {qh0, busy0, fnd0, exh0});
      end
      t_hd0 = 1'b1;
      @(negedge clk);
      t_hd0 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || hc0 !== 32'd0 || quits0 != q + 1) begin
         errors++;
         $display("FAIL stop_ignore: busy %b count %0d quits %0d, expected 0 0 1",
                  busy0, hc0, quits0 - q);
      end
   endtask

   task automatic test_stop_found();
      int q;
      new_template();
      nstart = 32'h10;
      nend = 32'h12;
      exp0.push_back(32'h10);
      pulse_start0();
      wait_launched0();
      repeat (5) @(negedge clk);
      q = quits0;
      vh0 = {8{32'hDEAD_BEEF}} ^ 256'h1234;
      t_hd0 = 1'b1;
      t_vf0 = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      t_hd0 = 1'b0;
      t_vf0 = 1'b0;
      stop = 1'b0;
      checks++;
      if (fnd0 !== 1'b1 || fn0 !== 32'h10 || hc0 !== 32'd1) begin
         errors++;
         $display("FAIL stopfound_result: fnd %b nonce %h count %0d, expected 1 10 1",
                  fnd0, fn0, hc0);
      end
      checks++;
      if (fh0 !== ({8{32'hDEAD_BEEF}} ^ 256'h1234)) begin
         errors++;
         $display("FAIL stopfound_hash: %h, expected deadbeef^1234", fh0);
      end
      pulse_stop();
      checks++;
      if ({fnd0, busy0, qh0} !== 3'b0 || fn0 !== 32'h10) begin
         errors++;
         $display("FAIL stopfound_clear: fnd/busy/quit %b nonce %h, expected 000 10",
                  {fnd0, busy0, qh0}, fn0);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (quits0 != q) begin
         errors++;
         $display("FAIL stopfound_noquit: %0d quit pulses, expected 0",
                  quits0 - q);
      end
   endtask

   task automatic test_reset_mid();
      int q;
      new_template();
      nstart = 32'h10;
      nend = 32'h12;
      exp0.push_back(32'h10);
      exp0.push_back(32'h11);
      pulse_start0();
      wait_launched0();
      repeat (3) @(negedge clk);
      t_hd0 = 1'b1;
      @(negedge clk);
      t_hd0 = 1'b0;
      wait_launched0();
      repeat (3) @(negedge clk);
      checks++;
      if (hc0 !== 32'd1 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: count %0d busy %b, expected 1 1",
                  hc0, busy0);
      end
      q = quits0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bh0, qh0, busy0, fnd0, exh0} !== 5'b0 || d0 !== '0 ||
          hc0 !== 32'd0 || fn0 !== 32'd0 || fh0 !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: flags %b count %0d, expected 0 0",
                  {bh0, qh0, busy0, fnd0, exh0}, hc0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (quits0 != q || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_quiet: quits %0d busy %b, expected 0 0",
                  quits0 - q, busy0);
      end
   endtask

   initial begin
      test_reset();
      test_exhaust();
      test_found();
      test_stride();
      test_wrap();
      test_stop();
      test_stop_found();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
